// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants, holding-slot payload
// and the baud divisor helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_BIT_CNT_W  = 3;
  localparam int unsigned UART_BAUD_CNT_W = 16;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  typedef struct packed {
    logic                      full;
    logic [UART_DATA_BITS-1:0] data;
  } uart_hold_t;

  // Clock cycles per bit; legal results are 2..65535.
  function automatic int unsigned uart_baud_cnt_max(input int unsigned clk_freq,
                                                    input int unsigned uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Enable-gated, clear-able bit-period counter; tick_c_o marks the last cycle
// of each bit period.
module uart_baud_tick #(
  parameter int unsigned CNT_MAX = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_c_o
);
  import uart_pkg::*;

  localparam logic [UART_BAUD_CNT_W-1:0] CNT_LAST = UART_BAUD_CNT_W'(CNT_MAX - 1);

  logic [UART_BAUD_CNT_W-1:0] cnt_q;
  logic [UART_BAUD_CNT_W-1:0] cnt_d;

  // Clear wins over counting; the terminal count wraps to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + UART_BAUD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c_o = en_i & (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 LSB-first UART transmitter with a one-byte holding slot so a byte
// strobed mid-frame is sent back-to-back after the current stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned uart_bps = 9600,
  parameter int unsigned clk_freq = 50000000
) (
  input  logic                      system_clk,
  input  logic                      system_rst,
  input  logic [UART_DATA_BITS-1:0] pi_data,
  input  logic                      pi_flag,
  output logic                      tx,
  output logic                      busy,
  output logic                      overrun
);

  localparam int unsigned BAUD_CNT_MAX = uart_baud_cnt_max(clk_freq, uart_bps);
  localparam logic [UART_BIT_CNT_W-1:0] LAST_BIT = UART_BIT_CNT_W'(UART_DATA_BITS - 1);

  uart_state_e               state_q;
  uart_state_e               state_d;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] shift_d;
  logic [UART_BIT_CNT_W-1:0] bit_cnt_q;
  logic [UART_BIT_CNT_W-1:0] bit_cnt_d;
  uart_hold_t                hold_q;
  uart_hold_t                hold_d;
  logic                      tx_q;
  logic                      tx_d;
  logic                      busy_q;
  logic                      busy_d;
  logic                      overrun_q;
  logic                      overrun_d;

  logic                      baud_tick_c;
  logic                      baud_en_c;
  logic                      start_entry_c;
  logic                      take_pi_c;

  assign baud_en_c     = (state_q != IDLE);
  assign start_entry_c = (state_d == START) && (state_q != START);

  uart_baud_tick #(
    .CNT_MAX (BAUD_CNT_MAX)
  ) u_baud_tick (
    .clk_i    (system_clk),
    .rst_i    (system_rst),
    .en_i     (baud_en_c),
    .clr_i    (start_entry_c),
    .tick_c_o (baud_tick_c)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    hold_d    = hold_q;
    overrun_d = 1'b0;
    take_pi_c = 1'b0;
    tx_d      = UART_IDLE_LEVEL;
    busy_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hold_q.full) begin
          state_d     = START;
          shift_d     = hold_q.data;
          hold_d.full = 1'b0;
        end else if (pi_flag) begin
          state_d   = START;
          shift_d   = pi_data;
          take_pi_c = 1'b1;
        end
      end
      START: begin
        if (baud_tick_c) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (baud_tick_c) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + UART_BIT_CNT_W'(1);
          end
        end
      end
      STOP: begin
        // A waiting byte (held, or strobed right now) starts with no idle gap.
        if (baud_tick_c) begin
          if (hold_q.full) begin
            state_d     = START;
            shift_d     = hold_q.data;
            hold_d.full = 1'b0;
          end else if (pi_flag) begin
            state_d   = START;
            shift_d   = pi_data;
            take_pi_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Sees the slot after any drain this cycle, so a coincident strobe fits.
    if (pi_flag && !take_pi_c) begin
      if (!hold_d.full) begin
        hold_d.full = 1'b1;
        hold_d.data = pi_data;
      end else begin
        overrun_d = 1'b1;
      end
    end

    unique case (state_d)
      IDLE:    tx_d = UART_IDLE_LEVEL;
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = UART_STOP_LEVEL;
      default: tx_d = UART_IDLE_LEVEL;
    endcase

    busy_d = (state_d != IDLE) | hold_d.full;
  end

  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      hold_q    <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      hold_q    <= hold_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter, 8N1, LSB first. Sits directly downstream of the UART receiver: takes the receiver's `po_data`/`po_flag` byte strobe (loopback/echo path) or any equivalent single-cycle byte strobe and serialises it onto `tx`. A one-byte holding register absorbs a byte arriving while a frame is in flight, so back-to-back receiver output is never lost at matched baud rates.

## Interface
- `uart_bps`, default 9600: line baud rate.
- `clk_freq`, default 50000000: `system_clk` frequency in Hz.
- `BAUD_CNT_MAX`, default `clk_freq/uart_bps` (derived, not overridden): clock cycles per bit; legal range 2..65535.

- `system_clk`  in  1  sole clock; all logic on rising edge.
- `system_rst`  in  1  reset: synchronous, active-high.
- `pi_data`  in  8  byte to send; sampled only when `pi_flag`=1.
- `pi_flag`  in  1  single-cycle byte strobe.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is in flight or the holding register is full.
- `overrun`  out  1  one-cycle pulse: strobed byte was dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `overrun`=0; FSM IDLE, holding register empty, counters 0. Reset mid-frame aborts immediately; `tx` returns high the cycle after reset is sampled.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when a byte is available (strobe or full holding register); byte loaded into shift register.
  - START: `tx`=0 for one bit period -> DATA.
  - DATA: `tx`=shift[0], shift right each bit; bit counter 0..7; after bit 7 period -> STOP.
  - STOP: `tx`=1 for one bit period; at its end -> START if holding register full (byte moved to shifter, register freed), else IDLE.
- Bit period: 16-bit baud counter counts 0..`BAUD_CNT_MAX`-1 while not IDLE; the terminal count ends the bit. Counter cleared on entry to START.
- Acceptance of `pi_flag`:
  - IDLE, holding empty: byte goes straight to shifter.
  - Frame in flight, holding empty: byte stored in holding register.
  - Holding full: byte dropped, holding contents unchanged, `overrun`=1 next cycle.
  - Strobe in the same cycle the holding register drains (end of STOP): the slot counts as free; new byte stored, no overrun.
- `busy` = (state != IDLE) | holding_full, registered consistently with state.

## Timing
- `pi_flag` at cycle N in IDLE -> `tx` low from cycle N+1; `busy` high from N+1.
- Each of start, 8 data, and stop bits lasts exactly `BAUD_CNT_MAX` cycles; full frame = 10×`BAUD_CNT_MAX` cycles.
- Queued byte: its start bit begins the cycle after the previous stop bit's last cycle (no idle gap).
- Last frame: `busy` falls the cycle after the stop bit's final cycle; `tx` stays high.
- `overrun` is exactly one cycle wide per dropped strobe.

## Structure
- Shared package `uart_pkg`: FSM state enum (IDLE/START/DATA/STOP), `UART_IDLE_LEVEL`=1, `UART_DATA_BITS`=8, and a function computing `BAUD_CNT_MAX` from `clk_freq`/`uart_bps`, shared with the receiver.
- One natural sub-module: `uart_baud_tick` (enable-gated, clear-able 16-bit counter emitting an end-of-bit tick), reusable by the receiver.

## Test plan
Use `clk_freq`=1000000, `uart_bps`=100000 (`BAUD_CNT_MAX`=10).
- Reset then idle 50 cycles -> `tx`=1, `busy`=0, `overrun`=0 throughout.
- Strobe 0xA5 in IDLE at cycle N -> `tx` low N+1..N+10, then bits 1,0,1,0,0,1,0,1 each 10 cycles, stop high 10 cycles; `busy` falls at N+101.
- Strobe 0x3C, then 0xC3 at cycle N+20 -> 0xC3 held, its start bit begins at N+101, no `overrun`, 200 total cycles of frames.
- Strobe 0x11, 0x22 at +5, 0x33 at +7 -> 0x33 dropped, `overrun` high one cycle at +8; line carries 0x11 then 0x22 only.
- Strobe coincident with the last stop cycle while holding full -> new byte accepted, `overrun`=0, three frames back-to-back.
- Assert `system_rst` mid-DATA of 0xFF-inverted byte 0x00 -> `tx`=1 and `busy`=0 one cycle later; subsequent strobe 0x5A sends a clean frame.
